// File: rtl/ex_muldiv_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_if
// Handshake and data bundle between the EX stage and the iterative
// multiply/divide unit.
//   start_i  : one-cycle start request from EX
//   op_i     : operation select (MUL/MULH/MULHU/DIV/MOD/DIVU/MODU)
//   opd1_i   : multiplicand / dividend
//   opd2_i   : multiplier / divisor
//   flush_i  : abort the operation in flight
//   busy_o   : operation in progress
//   done_o   : one-cycle completion pulse
//   result_o : last completed result
// master = EX stage side, slave = ex_muldiv side.
// ----------------------------------------------------------------------------
interface ex_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic [2:0]       op_i;
   logic [WIDTH-1:0] opd1_i;
   logic [WIDTH-1:0] opd2_i;
   logic             flush_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;

   modport master (
      output start_i, op_i, opd1_i, opd2_i, flush_i,
      input  busy_o, done_o, result_o
   );

   modport slave (
      input  start_i, op_i, opd1_i, opd2_i, flush_i,
      output busy_o, done_o, result_o
   );
endinterface

// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv
// Iterative multiply/divide engine for the EX stage. Radix-2 shift-add
// multiply and restoring divide, one bit per cycle, WIDTH cycles per op.
// Signed ops work on magnitudes; the result sign is applied on the final
// step. Divide-by-zero and signed overflow complete without iterating.
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous reset, active low
//   bus     : ex_muldiv_if.slave (start/op/operands/flush in,
//             busy/done/result out)
// ----------------------------------------------------------------------------
module ex_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   ex_muldiv_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [1:0] {SEL_LO, SEL_HI, SEL_QUO, SEL_REM} sel_t;

   state_t           r_state;
   sel_t             r_sel;
   logic             r_div;
   logic             r_neg;
   logic             r_busy;
   logic             r_done;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   r_hi;      // product high half / partial remainder
   logic [WIDTH-1:0] r_lo;      // multiplier / dividend-quotient shifter
   logic [WIDTH-1:0] r_opb;     // multiplicand / divisor magnitude
   logic [WIDTH-1:0] r_result;

   // ---- accept-time decode ----
   sel_t             w_sel;
   logic             w_signed;
   logic             w_is_div;
   logic             w_a_neg;
   logic             w_b_neg;
   logic             w_neg;
   logic [WIDTH-1:0] w_mag1;
   logic [WIDTH-1:0] w_mag2;
   logic             w_div0;
   logic             w_ovf;
   logic             w_special;
   logic [WIDTH-1:0] w_special_res;

   always_comb begin
      w_sel    = SEL_LO;
      w_signed = 1'b0;
      case (bus.op_i)
         3'd1: begin w_sel = SEL_HI;  w_signed = 1'b1; end
         3'd2: begin w_sel = SEL_HI;                   end
         3'd3: begin w_sel = SEL_QUO; w_signed = 1'b1; end
         3'd4: begin w_sel = SEL_REM; w_signed = 1'b1; end
         3'd5: begin w_sel = SEL_QUO;                  end
         3'd6: begin w_sel = SEL_REM;                  end
         default: ;
      endcase
   end

   assign w_is_div = (w_sel == SEL_QUO) || (w_sel == SEL_REM);
   assign w_a_neg  = w_signed & bus.opd1_i[WIDTH-1];
   assign w_b_neg  = w_signed & bus.opd2_i[WIDTH-1];
   // Remainder takes the dividend sign; product and quotient take the XOR.
   assign w_neg    = (w_sel == SEL_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
   assign w_mag1   = w_a_neg ? ('0 - bus.opd1_i) : bus.opd1_i;
   assign w_mag2   = w_b_neg ? ('0 - bus.opd2_i) : bus.opd2_i;

   assign w_div0    = w_is_div && (bus.opd2_i == '0);
   assign w_ovf     = w_is_div && w_signed && (bus.opd1_i == MINV) && (bus.opd2_i == '1);
   assign w_special = w_div0 || w_ovf;

   always_comb begin
      if (w_div0)
         w_special_res = (w_sel == SEL_QUO) ? '1 : bus.opd1_i;
      else
         w_special_res = (w_sel == SEL_QUO) ? MINV : '0;
   end

   // ---- one iteration step (shared registers for both algorithms) ----
   logic [WIDTH:0]   w_sum;
   logic [WIDTH+1:0] w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_ge;
   logic [WIDTH:0]   w_hi_n;
   logic [WIDTH-1:0] w_lo_n;

   assign w_sum   = r_hi + {1'b0, (r_lo[0] ? r_opb : '0)};
   assign w_shift = {r_hi, r_lo[WIDTH-1]};
   assign w_ge    = w_shift >= {2'b00, r_opb};
   assign w_diff  = w_shift[WIDTH:0] - {1'b0, r_opb};

   always_comb begin
      if (r_div) begin
         w_hi_n = w_ge ? w_diff : w_shift[WIDTH:0];
         w_lo_n = {r_lo[WIDTH-2:0], w_ge};
      end else begin
         w_hi_n = {1'b0, w_sum[WIDTH:1]};
         w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
      end
   end

   // ---- final sign correction and half/quotient/remainder select ----
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_c;
   logic [WIDTH-1:0]   w_quo_c;
   logic [WIDTH-1:0]   w_rem_c;
   logic [WIDTH-1:0]   w_final;

   assign w_prod   = {w_hi_n[WIDTH-1:0], w_lo_n};
   assign w_prod_c = r_neg ? ('0 - w_prod) : w_prod;
   assign w_quo_c  = r_neg ? ('0 - w_lo_n) : w_lo_n;
   assign w_rem_c  = r_neg ? ('0 - w_hi_n[WIDTH-1:0]) : w_hi_n[WIDTH-1:0];

   always_comb begin
      case (r_sel)
         SEL_HI:  w_final = w_prod_c[2*WIDTH-1:WIDTH];
         SEL_QUO: w_final = w_quo_c;
         SEL_REM: w_final = w_rem_c;
         default: w_final = w_prod_c[WIDTH-1:0];
      endcase
   end

   // ---- control FSM ----
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state  <= S_IDLE;
         r_sel    <= SEL_LO;
         r_div    <= 1'b0;
         r_neg    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opb    <= '0;
         r_result <= '0;
      end else if (bus.flush_i) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start_i) begin
                  r_sel <= w_sel;
                  r_div <= w_is_div;
                  r_neg <= w_neg;
                  r_hi  <= '0;
                  r_lo  <= w_is_div ? w_mag1 : w_mag2;
                  r_opb <= w_is_div ? w_mag2 : w_mag1;
                  r_cnt <= CW'(WIDTH - 1);
                  if (w_special) begin
                     r_result <= w_special_res;
                     r_state  <= S_DONE;
                     r_done   <= 1'b1;
                     r_busy   <= 1'b0;
                  end else begin
                     r_state <= S_RUN;
                     r_busy  <= 1'b1;
                  end
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            S_RUN: begin
               r_hi  <= w_hi_n;
               r_lo  <= w_lo_n;
               r_cnt <= r_cnt - CW'(1);
               // Last step's result is corrected and registered on the
               // same edge that enters DONE.
               if (r_cnt == '0) begin
                  r_state  <= S_DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_result <= w_final;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy_o   = r_busy;
   assign bus.done_o   = r_done;
   assign bus.result_o = r_result;
endmodule

// File: tb/tb_ex_muldiv.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv
// Directed bench for ex_muldiv at WIDTH=32 and WIDTH=8, plus a small
// signed/unsigned sweep at WIDTH=8 against an arithmetic reference.
// ----------------------------------------------------------------------------
module tb_ex_muldiv;
   localparam logic [2:0] OP_MUL   = 3'd0;
   localparam logic [2:0] OP_MULH  = 3'd1;
   localparam logic [2:0] OP_MULHU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_MOD   = 3'd4;
   localparam logic [2:0] OP_DIVU  = 3'd5;
   localparam logic [2:0] OP_MODU  = 3'd6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [31:0] last32 = '0;

   always #5 clk = ~clk;

   ex_muldiv_if #(.WIDTH(32)) if32 ();
   ex_muldiv_if #(.WIDTH(8))  if8  ();

   ex_muldiv #(.WIDTH(32)) u_dut32 (.clk_i(clk), .rst_n_i(rst_n), .bus(if32.slave));
   ex_muldiv #(.WIDTH(8))  u_dut8  (.clk_i(clk), .rst_n_i(rst_n), .bus(if8.slave));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit w8, input logic st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      if (w8) begin
         if8.start_i = st; if8.op_i = op; if8.opd1_i = a[7:0]; if8.opd2_i = b[7:0];
      end else begin
         if32.start_i = st; if32.op_i = op; if32.opd1_i = a; if32.opd2_i = b;
      end
   endtask

   task automatic sample(input bit w8, output logic dn, output logic bz, output logic [31:0] res);
      if (w8) begin
         dn = if8.done_o; bz = if8.busy_o; res = {24'b0, if8.result_o};
      end else begin
         dn = if32.done_o; bz = if32.busy_o; res = if32.result_o;
      end
   endtask

   // Starts an op at the current negedge (cycle 0) and returns at the
   // negedge of its DONE cycle, so a following call starts back-to-back.
   task automatic run_op(input bit w8, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input string tag);
      int n;
      bit busy_ok;
      logic dn, bz;
      logic [31:0] res;
      drive(w8, 1'b1, op, a, b);
      @(negedge clk);
      drive(w8, 1'b0, ~op, ~a, ~b);   // operands must already be captured
      n = 1;
      busy_ok = 1'b1;
      sample(w8, dn, bz, res);
      while (!dn && n < 80) begin
         if (!bz) busy_ok = 1'b0;
         @(negedge clk);
         n++;
         sample(w8, dn, bz, res);
      end
      check({tag, "_latency"}, 64'(n), 64'(lat));
      check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
      check({tag, "_busy_at_done"}, 64'(bz), 64'd0);
      check({tag, "_result"}, 64'(res), 64'(exp));
      if (!w8) last32 = exp;
   endtask

   task automatic quiet(input int cycles, input string tag);
      bit seen;
      seen = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         if (if32.done_o !== 1'b0) seen = 1'b1;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   function automatic logic [7:0] ref8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] sa, sb, sp;
      logic [15:0] up;
      logic signed [7:0] a8, b8;
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      sp = sa * sb;
      up = {8'b0, a} * {8'b0, b};
      a8 = a;
      b8 = b;
      case (op)
         OP_MULH:  return sp[15:8];
         OP_MULHU: return up[15:8];
         OP_DIV:   return (b == 0) ? 8'hFF : (a == 8'h80 && b == 8'hFF) ? 8'h80 : 8'(a8 / b8);
         OP_MOD:   return (b == 0) ? a : (a == 8'h80 && b == 8'hFF) ? 8'h00 : 8'(a8 % b8);
         OP_DIVU:  return (b == 0) ? 8'hFF : a / b;
         OP_MODU:  return (b == 0) ? a : a % b;
         default:  return up[7:0];
      endcase
   endfunction

   initial begin
      logic [2:0] rop;
      logic [7:0] ra, rb;
      int rlat;
      if32.flush_i = 1'b0;
      if8.flush_i  = 1'b0;
      drive(1'b0, 1'b0, OP_MUL, 32'd0, 32'd0);
      drive(1'b1, 1'b0, OP_MUL, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(if32.busy_o), 64'd0);
      check("rst_done", 64'(if32.done_o), 64'd0);
      check("rst_result", 64'(if32.result_o), 64'd0);
      check("rst_result8", 64'(if8.result_o), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // WIDTH=32 multiply, second op started in the DONE cycle of the first
      run_op(1'b0, OP_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul");
      run_op(1'b0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "b2b_mulhu");
      @(negedge clk);
      run_op(1'b0, OP_MULH,  32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh");
      @(negedge clk);
      run_op(1'b0, OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div");
      @(negedge clk);
      run_op(1'b0, OP_MOD,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "mod");
      @(negedge clk);
      run_op(1'b0, OP_DIVU,  32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33, "divu");
      @(negedge clk);
      run_op(1'b0, OP_DIVU,  32'd100,      32'd0,        32'hFFFFFFFF, 1,  "divu_by0");
      @(negedge clk);
      run_op(1'b0, OP_MODU,  32'd100,      32'd0,        32'd100,      1,  "modu_by0");
      @(negedge clk);
      run_op(1'b0, OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf");
      @(negedge clk);
      run_op(1'b0, OP_MOD,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "mod_ovf");
      @(negedge clk);
      run_op(1'b0, OP_MUL,   32'd1234,     32'd5678,     32'd7006652,  33, "mul_pos");

      // flush in cycle 10 of a multiply
      @(negedge clk);
      drive(1'b0, 1'b1, OP_MUL, 32'd5, 32'd6);
      @(negedge clk);
      drive(1'b0, 1'b0, OP_MUL, 32'd0, 32'd0);
      repeat (9) @(negedge clk);
      if32.flush_i = 1'b1;
      @(negedge clk);
      if32.flush_i = 1'b0;
      check("flush_busy", 64'(if32.busy_o), 64'd0);
      quiet(40, "flush_no_done");
      check("flush_result_held", 64'(if32.result_o), 64'(last32));

      // flush and start together in IDLE
      drive(1'b0, 1'b1, OP_MUL, 32'd3, 32'd3);
      if32.flush_i = 1'b1;
      @(negedge clk);
      if32.flush_i = 1'b0;
      drive(1'b0, 1'b0, OP_MUL, 32'd0, 32'd0);
      check("flushstart_busy", 64'(if32.busy_o), 64'd0);
      quiet(40, "flushstart_no_done");
      check("flushstart_result_held", 64'(if32.result_o), 64'(last32));

      // asynchronous reset in cycle 5
      drive(1'b0, 1'b1, OP_MUL, 32'hFFFF, 32'hFFFF);
      @(negedge clk);
      drive(1'b0, 1'b0, OP_MUL, 32'd0, 32'd0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(if32.busy_o), 64'd0);
      check("midrst_done", 64'(if32.done_o), 64'd0);
      check("midrst_result", 64'(if32.result_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet(40, "midrst_no_done");

      // WIDTH=8
      @(negedge clk);
      run_op(1'b1, OP_MULHU, 32'hFF, 32'hFF, 32'hFE, 9, "w8_mulhu");
      @(negedge clk);
      run_op(1'b1, OP_DIV,   32'h80, 32'hFF, 32'h80, 1, "w8_div_ovf");
      @(negedge clk);
      run_op(1'b1, 3'd7,     32'd3,  32'd5,  32'h0F, 9, "w8_op7");
      @(negedge clk);
      run_op(1'b1, OP_MOD,   32'hF9, 32'd2,  32'hFF, 9, "w8_mod");

      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         if (i == 4) rb = 8'h00;
         if (i == 9) begin ra = 8'h80; rb = 8'hFF; rop = OP_MOD; end
         rlat = ((rop >= OP_DIV && rop <= OP_MODU && rb == 8'h00) ||
                 ((rop == OP_DIV || rop == OP_MOD) && ra == 8'h80 && rb == 8'hFF)) ? 1 : 9;
         @(negedge clk);
         run_op(1'b1, rop, {24'b0, ra}, {24'b0, rb}, {24'b0, ref8(rop, ra, rb)}, rlat, "w8_sweep");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised iterative multiply/divide unit for the EX stage; it replaces the single-cycle `*` path with a multi-cycle engine that also covers division and remainder. It sits beside the ALU in EX. EX starts it with a one-cycle pulse and holds the EX over signal low until `done_o` is asserted. The unit supports signed/unsigned high and low products and signed/unsigned quotient and remainder. The datapath width is set by a parameter, and EX can cancel an operation in flight.

## Interface
- `WIDTH`, default 32: operand and result width; must be at least 2.
- `clk_i`, input, 1: clock; all state changes on the rising edge.
- `rst_n_i`, input, 1: asynchronous reset, active low.
- `start_i`, input, 1: start request; sampled only while `busy_o` = 0.
- `op_i`, input, 3: operation select.
  - 0 MUL (low half)
  - 1 MULH (signed, high half)
  - 2 MULHU (unsigned, high half)
  - 3 DIV (signed quotient)
  - 4 MOD (signed remainder)
  - 5 DIVU (unsigned quotient)
  - 6 MODU (unsigned remainder)
  - 7 executes as MUL
- `opd1_i`, input, WIDTH: multiplicand or dividend.
- `opd2_i`, input, WIDTH: multiplier or divisor.
- `flush_i`, input, 1: abort the current operation.
- `busy_o`, output, 1: operation in progress; new starts are ignored while high.
- `done_o`, output, 1: one-cycle pulse; `result_o` is valid in this cycle.
- `result_o`, output, WIDTH: last completed result; held until the next completion.

## Operation
- **Operand capture.** Operands and op are latched when the start is accepted; later input changes have no effect.
- **Signed ops** (MULH, DIV, MOD): operands are converted to magnitudes and the required result signs are recorded.
  - Product sign = XOR of the operand sign bits.
  - Quotient sign = XOR of the operand sign bits.
  - Remainder sign = dividend sign.
- **Unsigned ops and MUL:** operands are used as-is. The low half of the product is sign-independent.
- **Multiply:** radix-2 shift-add over WIDTH steps into a 2·WIDTH accumulator. The sign correction (two's complement of the full 2·WIDTH product) is applied before the half is selected.
- **Divide:** restoring division, one quotient bit per step, WIDTH steps. The remainder register is WIDTH+1 bits.
- **Divide special cases** are detected at accept and bypass iteration:
  - Divisor = 0: quotient = all ones; remainder = `opd1_i`.
  - Signed overflow (dividend = 100…0, divisor = all ones): quotient = 100…0; remainder = 0.
- **States:**
  - IDLE: `start_i` with no `flush_i` goes to RUN, or to DONE for a special case.
  - RUN: the step counter (clog2(WIDTH)+1 bits) loads WIDTH−1 and decrements each cycle. At count 0 the state moves to DONE, and the sign-corrected, selected result is registered into `result_o` on that same edge.
  - DONE: asserts `done_o`, deasserts `busy_o`, and returns to IDLE. A `start_i` in DONE is accepted exactly as in IDLE.
- **Flush:** `flush_i` in any state forces IDLE on the next edge.
  - No `done_o` is asserted for the aborted operation and `result_o` is unchanged.
  - When `flush_i` and `start_i` are high in the same cycle, the flush wins and the start is dropped.
- **Reset** (asynchronous, any state, including mid-operation):
  - State goes to IDLE.
  - `busy_o` = 0, `done_o` = 0, `result_o` = 0, counter = 0.

## Timing
- Cycle 0: `start_i` is accepted.
- Cycles 1..WIDTH: RUN; `busy_o` = 1.
- Cycle WIDTH+1: DONE; `done_o` = 1, `busy_o` = 0, `result_o` valid. Latency is therefore WIDTH+1 cycles (33 at the default width).
- Special-case divides: DONE in cycle 1, so latency is 1.
- Back-to-back operation: a start accepted in a DONE cycle enters RUN in the next cycle, giving a throughput of one operation per WIDTH+1 cycles.
- `busy_o` and `done_o` are never high in the same cycle.
- `result_o` changes only on the edge that enters DONE.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Multiply, WIDTH=32:**
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, with `done_o` exactly in cycle 33 and `busy_o` high in cycles 1–32.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- **Signed divide, WIDTH=32:**
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - MOD of the same operands → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- **Special cases:**
  - DIVU 100 / 0 → 0xFFFFFFFF with `done_o` in cycle 1; MODU 100 / 0 → 100.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; MOD of the same operands → 0.
- **Flush:**
  - Start MUL, assert `flush_i` in cycle 10: `busy_o` = 0 in cycle 11, no `done_o`, previous `result_o` retained.
  - `flush_i` together with `start_i` in IDLE: the start is ignored.
- **Back-to-back:**
  - Assert `start_i` in the DONE cycle of the first operation: the second operation completes exactly 33 cycles later with the correct value.
  - Assert `rst_n_i` low in cycle 5 of an operation: all outputs go to 0 immediately, with no `done_o` afterwards.
- **WIDTH=8:**
  - MULHU 0xFF × 0xFF → 0xFE; DIV 0x80 / 0xFF → 0x80.
  - Latency is 9 cycles.
  - Random signed/unsigned sweep against a reference model.
